// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - State encodings and step-counter width helper for the Huffman control sequencer.
package huff_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_COUNT  = 3'd1;
    localparam logic [2:0] ST_CNTV   = 3'd2;
    localparam logic [2:0] ST_SORT   = 3'd3;
    localparam logic [2:0] ST_DECODE = 3'd4;
    localparam logic [2:0] ST_CODEV  = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    function automatic int huff_cnt_w(input int n_sym);
        return (n_sym > 1) ? $clog2(n_sym) : 1;
    endfunction

endpackage

// File: rtl/huff_step_cnt.sv
// rtl/huff_step_cnt.sv - Up/down step counter with clear and terminal-count flags.
module huff_step_cnt #(
    parameter int CNT_W = 3,
    parameter int TOP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             up,
    input  logic             down,
    output logic [CNT_W-1:0] cnt,
    output logic             at_top,
    output logic             at_zero
);

    localparam logic [CNT_W-1:0] TOP_V = CNT_W'(TOP);
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_top  = (cnt_q == TOP_V);
    assign at_zero = (cnt_q == '0);
    assign cnt     = cnt_q;

    // The count holds at either terminal so the FSM sees a stable index on its exit cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (up && !at_top) begin
            cnt_d = cnt_q + ONE_V;
        end else if (down && !at_zero) begin
            cnt_d = cnt_q - ONE_V;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/huff_seq_ctrl.sv
// rtl/huff_seq_ctrl.sv - Count/sort/decode/code-valid sequencer; HUFF_SEQ_ERR_EN adds a sticky ERR state.
module huff_seq_ctrl
    import huff_pkg::*;
#(
    parameter int N_SYM   = 6,
    parameter int MAX_PIX = 100,
    parameter int CNT_W   = huff_cnt_w(N_SYM),
    parameter int PIX_W   = $clog2(MAX_PIX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gray_valid,
    input  logic             code_ready,
    output logic             CNT_valid,
    output logic             code_valid,
    output logic             sort_en,
    output logic             decode_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] counter,
    output logic [PIX_W-1:0] pix_cnt
);

    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(MAX_PIX);
    localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);

    logic [2:0]       state_q, state_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             cnt_valid_q, cnt_valid_d;
    logic             code_valid_q, code_valid_d;
    logic             sort_en_q, sort_en_d;
    logic             decode_en_q, decode_en_d;
    logic             at_top, at_zero;
    logic             pix_last;
    logic             busy_gray;

`ifdef HUFF_SEQ_ERR_EN
    assign busy_gray = gray_valid;
`else
    assign busy_gray = 1'b0;
`endif

    assign pix_last = ((pix_q + PIX_ONE) == PIX_MAX);

    huff_step_cnt #(
        .CNT_W (CNT_W),
        .TOP   (N_SYM - 2)
    ) u_step_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (!((state_q == ST_SORT) || (state_q == ST_DECODE))),
        .up      (state_q == ST_SORT),
        .down    (state_q == ST_DECODE),
        .cnt     (counter),
        .at_top  (at_top),
        .at_zero (at_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pix_q        <= '0;
            cnt_valid_q  <= 1'b0;
            code_valid_q <= 1'b0;
            sort_en_q    <= 1'b0;
            decode_en_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            cnt_valid_q  <= cnt_valid_d;
            code_valid_q <= code_valid_d;
            sort_en_q    <= sort_en_d;
            decode_en_q  <= decode_en_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = gray_valid ? ((MAX_PIX == 1) ? ST_CNTV : ST_COUNT) : ST_IDLE;
            ST_COUNT:  state_d = (!gray_valid || pix_last) ? ST_CNTV : ST_COUNT;
            ST_CNTV:   state_d = busy_gray ? ST_ERR : ST_SORT;
            ST_SORT:   state_d = busy_gray ? ST_ERR : (at_top ? ST_DECODE : ST_SORT);
            ST_DECODE: state_d = busy_gray ? ST_ERR : (at_zero ? ST_CODEV : ST_DECODE);
            ST_CODEV:  state_d = code_ready ? ST_IDLE : ST_CODEV;
`ifdef HUFF_SEQ_ERR_EN
            ST_ERR:    state_d = ST_ERR;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the registered copies line up with state.
    always_comb begin
        cnt_valid_d  = (state_d == ST_CNTV);
        sort_en_d    = (state_d == ST_SORT);
        decode_en_d  = (state_d == ST_DECODE);
        code_valid_d = (state_d == ST_CODEV);
        pix_d        = pix_q;
        if (state_q == ST_IDLE) begin
            pix_d = gray_valid ? PIX_ONE : '0;
        end else if ((state_q == ST_COUNT) && gray_valid) begin
            pix_d = pix_q + PIX_ONE;
        end
        if (state_d == ST_IDLE) begin
            pix_d = '0;
        end
    end

    assign state      = state_q;
    assign pix_cnt    = pix_q;
    assign CNT_valid  = cnt_valid_q;
    assign code_valid = code_valid_q;
    assign sort_en    = sort_en_q;
    assign decode_en  = decode_en_q;

endmodule

// File: tb/tb_huff_seq_ctrl.sv
// tb/tb_huff_seq_ctrl.sv - Scoreboard bench for huff_seq_ctrl at N_SYM = 6, 3 and 16 sharing one stimulus.
`timescale 1ns/1ps
module tb_huff_seq_ctrl;

    localparam int MAXP = 100;
    localparam int ND   = 3;
    localparam int M_IDLE  = 0;
    localparam int M_CNT   = 1;
    localparam int M_BUSY  = 2;
    localparam int M_OFFER = 3;

    typedef struct {
        int pix;
        int at;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       gray_valid;
    logic       code_ready;
    logic       cntv_w [ND];
    logic       cv_w   [ND];
    logic       se_w   [ND];
    logic       de_w   [ND];
    logic [2:0] st_w   [ND];
    logic [6:0] pix_w  [ND];
    logic [2:0] cnt0;
    logic [1:0] cnt1;
    logic [3:0] cnt2;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    int   m_mode  [ND];
    int   m_pix   [ND];
    int   m_offer [ND];
    exp_t exp_q   [ND][$];

    int   sort_seen [ND];
    int   dec_seen  [ND];
    int   cntv_seen [ND];
    int   first_cv  [ND];
    logic hs_prev   [ND];

    always #5 clk = ~clk;

    huff_seq_ctrl #(.N_SYM(6), .MAX_PIX(MAXP)) u_n6 (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .code_ready(code_ready),
        .CNT_valid(cntv_w[0]), .code_valid(cv_w[0]), .sort_en(se_w[0]), .decode_en(de_w[0]),
        .state(st_w[0]), .counter(cnt0), .pix_cnt(pix_w[0])
    );

    huff_seq_ctrl #(.N_SYM(3), .MAX_PIX(MAXP)) u_n3 (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .code_ready(code_ready),
        .CNT_valid(cntv_w[1]), .code_valid(cv_w[1]), .sort_en(se_w[1]), .decode_en(de_w[1]),
        .state(st_w[1]), .counter(cnt1), .pix_cnt(pix_w[1])
    );

    huff_seq_ctrl #(.N_SYM(16), .MAX_PIX(MAXP)) u_n16 (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .code_ready(code_ready),
        .CNT_valid(cntv_w[2]), .code_valid(cv_w[2]), .sort_en(se_w[2]), .decode_en(de_w[2]),
        .state(st_w[2]), .counter(cnt2), .pix_cnt(pix_w[2])
    );

    function automatic int nsym_of(input int d);
        return (d == 0) ? 6 : ((d == 1) ? 3 : 16);
    endfunction

    function automatic int cnt_of(input int d);
        case (d)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int strobes_of(input int d);
        return int'({cntv_w[d], cv_w[d], se_w[d], de_w[d]});
    endfunction

    task automatic check(input int d, input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s [N_SYM=%0d cyc=%0d]: got %0d, expected %0d", name, nsym_of(d), cyc, act, expv);
        end
    endtask

    // Frame-level reference: count pixels, then a fixed 2*N-cycle wait until the code set is offered.
    task automatic model_step(input int d, input logic gv, input logic cr);
        int n;
        n = nsym_of(d);
        case (m_mode[d])
            M_IDLE: begin
                if (gv) begin
                    m_pix[d]  = 1;
                    m_mode[d] = M_CNT;
                end
            end
            M_CNT: begin
                if (gv) m_pix[d] = m_pix[d] + 1;
                if (!gv || (m_pix[d] == MAXP)) begin
                    exp_q[d].push_back('{pix: m_pix[d], at: cyc + 2 * n});
                    m_offer[d] = cyc + 2 * n;
                    m_mode[d]  = M_BUSY;
                end
            end
            M_BUSY: begin
                if (cyc + 1 == m_offer[d]) m_mode[d] = M_OFFER;
            end
            default: begin
                if (cr) m_mode[d] = M_IDLE;
            end
        endcase
    endtask

    task automatic drive(input logic gv, input logic cr);
        @(posedge clk);
        #1;
        cyc        = cyc + 1;
        gray_valid = gv;
        code_ready = cr;
        for (int d = 0; d < ND; d++) model_step(d, gv, cr);
    endtask

    task automatic drive_rand(input int gp, input int cp);
        drive(int'($urandom_range(99)) < gp, int'($urandom_range(99)) < cp);
    endtask

    task automatic monitor_dut(input int d);
        int   n;
        exp_t e;
        n = nsym_of(d);
        if (hs_prev[d]) begin
            check(d, "idle_after_accept", int'(st_w[d]), 0);
            check(d, "pix_clear_in_idle", int'(pix_w[d]), 0);
            hs_prev[d] = 1'b0;
        end
        if (cntv_w[d]) cntv_seen[d]++;
        if (se_w[d]) begin
            check(d, "sort_counter", cnt_of(d), sort_seen[d]);
            sort_seen[d]++;
        end
        if (de_w[d]) begin
            check(d, "decode_counter", cnt_of(d), n - 2 - dec_seen[d]);
            dec_seen[d]++;
        end
        if (cv_w[d]) begin
            if (first_cv[d] < 0) first_cv[d] = cyc;
            check(d, "codev_state", int'(st_w[d]), 5);
            if (code_ready) begin
                if (exp_q[d].size() == 0) begin
                    check(d, "unexpected_code_valid", 1, 0);
                end else begin
                    e = exp_q[d].pop_front();
                    check(d, "pix_cnt", int'(pix_w[d]), e.pix);
                    check(d, "code_valid_cycle", first_cv[d], e.at);
                    check(d, "sort_cycles", sort_seen[d], n - 1);
                    check(d, "decode_cycles", dec_seen[d], n - 1);
                    check(d, "cnt_valid_pulses", cntv_seen[d], 1);
                end
                sort_seen[d] = 0;
                dec_seen[d]  = 0;
                cntv_seen[d] = 0;
                first_cv[d]  = -1;
                hs_prev[d]   = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < ND; d++) monitor_dut(d);
        end
    end

    initial begin
        int   gps [4];
        int   cps [3];
        logic found;
        gps = '{100, 85, 40, 5};
        cps = '{100, 60, 15};
        for (int d = 0; d < ND; d++) begin
            m_mode[d]    = M_IDLE;
            m_pix[d]     = 0;
            m_offer[d]   = 0;
            sort_seen[d] = 0;
            dec_seen[d]  = 0;
            cntv_seen[d] = 0;
            first_cv[d]  = -1;
            hs_prev[d]   = 1'b0;
        end
        reset      = 1'b0;
        gray_valid = 1'b0;
        code_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check(d, "reset_state", int'(st_w[d]), 0);
            check(d, "reset_counter", cnt_of(d), 0);
            check(d, "reset_pix_cnt", int'(pix_w[d]), 0);
            check(d, "reset_strobes", strobes_of(d), 0);
        end
        reset = 1'b1;

`ifndef HUFF_SEQ_ERR_EN
        mon_en = 1'b1;
        // 10-pixel frame, then seven cycles of backpressure once N_SYM=6 offers its codes
        repeat (10) drive(1'b1, 1'b0);
        repeat (19) drive(1'b0, 1'b0);
        repeat (40) drive(1'b0, 1'b1);
        // Saturation: 120 pixels offered, only the first MAXP counted
        repeat (120) drive(1'b1, 1'b0);
        repeat (40) drive(1'b0, 1'b1);
        for (int s = 0; s < 60; s++) begin
            int len, gp, cp;
            len = int'($urandom_range(40, 1));
            gp  = gps[$urandom_range(3)];
            cp  = cps[$urandom_range(2)];
            repeat (len) drive_rand(gp, cp);
        end
        repeat (60) drive(1'b0, 1'b1);
        @(negedge clk);
        mon_en = 1'b0;
        for (int d = 0; d < ND; d++) check(d, "frames_left_unseen", exp_q[d].size(), 0);

        // Asynchronous reset in the middle of SORT with counter=2
        drive(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            drive(1'b0, 1'b0);
            if (se_w[0] && (cnt0 == 3'd2)) found = 1'b1;
        end
        check(0, "reach_sort_counter2", int'(found), 1);
        #3;
        reset = 1'b0;
        #1;
        check(0, "async_reset_state", int'(st_w[0]), 0);
        check(0, "async_reset_counter", cnt_of(0), 0);
        check(0, "async_reset_strobes", strobes_of(0), 0);
        check(0, "async_reset_pix", int'(pix_w[0]), 0);
`else
        drive(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            drive(1'b0, 1'b0);
            if (se_w[0]) found = 1'b1;
        end
        check(0, "reach_sort", int'(found), 1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        check(0, "err_state", int'(st_w[0]), 6);
        check(0, "err_strobes", strobes_of(0), 0);
        repeat (20) drive(1'b1, 1'b1);
        check(0, "err_held_state", int'(st_w[0]), 6);
        check(0, "err_held_strobes", strobes_of(0), 0);
        #3;
        reset = 1'b0;
        #1;
        check(0, "err_reset_state", int'(st_w[0]), 0);
        check(0, "err_reset_strobes", strobes_of(0), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
